buzzer_scheduler: RTL and testbench
===================================

# buzzer_scheduler

Shares the board's single buzzer pin between the ten 4-bit game counters held in the `status` vector. Each counter that wraps to zero raises an event. The block queues one pending flag per counter and grants the pin round-robin. The winner gets a fixed-length tone whose pitch encodes its slot index, followed by a silent gap. It replaces the per-counter buzzer instances and their OR into `buzzer_pin`, so simultaneous wraps are heard one after another rather than merged.

## Interface
- `N_SLOT`, 10: number of 4-bit counters in `status`.
- `TONE_CYCLES`, 25_000_000: clock cycles a granted tone lasts (≥1).
- `GAP_CYCLES`, 5_000_000: silent cycles after each tone (≥1).
- `BASE_HALF`, 50_000: half-period, in cycles, of slot 0's tone (≥1).
- `STEP_HALF`, 5_000: half-period increment per slot index.
- `clk`  in  1: system clock; every register updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `status`  in  4*N_SLOT: counter values; slot i is `status[4*i +: 4]`.
- `enable`  in  1: when low, no new grant is issued; detection and queuing continue.
- `buzzer_pin`  out  1: square-wave tone output.
- `busy`  out  1: high in PLAY or GAP.
- `active_slot`  out  4: slot being played or last played.
- `pending`  out  N_SLOT: queued-event flags.

## Operation
- Reset values (applied immediately while `rst` is high):
  - `buzzer_pin`=0, `busy`=0, `active_slot`=0, `pending`=0.
  - Stored previous-nibble copies `prev[i]`=0.
  - Round-robin pointer `last`=N_SLOT-1, so slot 0 has top priority first.
  - State=IDLE.
- Event detection, every edge, for each slot i:
  - `evt[i]` = (`prev[i]`≠0) and (current nibble = 0).
  - `prev[i]` is then loaded with the current nibble.
  - A nonzero→zero change is the only trigger. A counter that is 0 at reset or stays at 0 fires nothing.
- Pending update: `pending[i]` is set by `evt[i]` and cleared by a grant to i.
  - A grant and a new event for the same slot on the same edge leave `pending[i]`=1, so one replay follows.
  - An event on an already-pending slot merges; there is no count.
- Arbitration: the winner is the first pending slot searching `last+1, last+2, …` modulo N_SLOT. On a grant, `last`←winner.
- State machine:
  - IDLE: if `enable` and `pending`≠0, grant:
    - `active_slot`←winner; clear its pending bit.
    - Load tone counter with TONE_CYCLES-1.
    - Load half-period counter with H-1, where H = BASE_HALF + winner·STEP_HALF.
    - Drive `buzzer_pin`←1 and go to PLAY.
  - PLAY:
    - Half-period counter reaching 0 toggles `buzzer_pin` and reloads H-1.
    - Tone counter reaching 0 clears `buzzer_pin`, loads the gap counter with GAP_CYCLES-1, and goes to GAP.
  - GAP: `buzzer_pin`=0. When the gap counter reaches 0:
    - If `enable` and `pending`≠0, grant immediately as from IDLE, going straight to PLAY.
    - Otherwise go to IDLE.
- `enable` falling during PLAY or GAP does not abort; the current tone and gap complete.
- Width rules:
  - H is computed in 32 bits.
  - Tone, gap and half-period counters are 32-bit unsigned down-counters.
  - `active_slot` is zero-extended to 4 bits.

## Timing
- A nibble changing to 0 before edge k sets `pending` at edge k. The grant occurs at edge k+1, with `buzzer_pin`=1 from k+1 if the block is IDLE.
- The tone occupies exactly TONE_CYCLES cycles and the gap exactly GAP_CYCLES cycles, so back-to-back grants are TONE_CYCLES+GAP_CYCLES cycles apart.
- Within a tone, `buzzer_pin` toggles every H cycles: first toggle at grant+H.
- `busy` rises on the grant edge and falls on the GAP→IDLE edge. With continuous demand it stays high across grants.
- `rst` asserted mid-tone drops `buzzer_pin` and `busy` asynchronously and discards all pending flags.

## Test plan
Use TONE_CYCLES=20, GAP_CYCLES=4, BASE_HALF=2, STEP_HALF=1, N_SLOT=10.
1. Single event: slot 3 goes 1→0 at edge 10.
   - `pending`=0x008 after edge 10.
   - Grant at edge 11 with `active_slot`=3, H=5.
   - `buzzer_pin` toggles at 16, 21, 26; low at edge 31.
   - `busy` falls at edge 35.
2. Simultaneous wraps: slots 0, 4, 9 wrap on the same edge after reset.
   - Play order is 0, 4, 9.
   - Grant edges are 24 cycles apart; `busy` stays high throughout.
3. Round-robin fairness: after slot 4 plays, slots 2 and 6 become pending together.
   - Slot 6 plays before slot 2.
4. Re-trigger during own tone: slot 5 wraps again mid-PLAY.
   - `pending[5]`=1, and slot 5 replays after the gap.
   - Same-edge grant and event on one slot also yields exactly one replay.
5. No false trigger and enable gating:
   - `status` held at 0 from reset → no events.
   - With `enable`=0, a wrap sets `pending` but no grant occurs.
   - Raising `enable` grants on the next edge.
6. Async reset mid-PLAY: assert `rst` between edges.
   - `buzzer_pin`, `busy` and `pending` go 0 immediately.
   - After release, slot 0 wins first.

Source files
------------

// File: rtl/buzzer_scheduler_if.sv
// Bundles the buzzer scheduler's data signals.
//   status      : N_SLOT packed 4-bit game counters (slot i at [4*i +: 4])
//   enable      : allows new grants when high
//   buzzer_pin  : square-wave tone output
//   busy        : high while a tone or its trailing gap is in progress
//   active_slot : slot being played or last played
//   pending     : one queued-event flag per slot
// master drives status/enable and observes the rest; slave is the scheduler.
interface buzzer_scheduler_if #(
  parameter int unsigned N_SLOT = 10
);
  logic [4*N_SLOT-1:0] status;
  logic                enable;
  logic                buzzer_pin;
  logic                busy;
  logic [3:0]          active_slot;
  logic [N_SLOT-1:0]   pending;

  modport master (
    output status, enable,
    input  buzzer_pin, busy, active_slot, pending
  );

  modport slave (
    input  status, enable,
    output buzzer_pin, busy, active_slot, pending
  );
endinterface

// File: rtl/buzzer_scheduler.sv
// Shares one buzzer pin between N_SLOT 4-bit counters. A counter changing from a
// nonzero value to zero queues a pending flag for its slot; pending slots are granted
// round-robin. Each grant plays a TONE_CYCLES tone whose half-period is
// BASE_HALF + slot*STEP_HALF cycles, followed by GAP_CYCLES of silence.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : buzzer_scheduler_if slave modport (status, enable in; pin, busy,
//         active_slot, pending out)
module buzzer_scheduler #(
  parameter int unsigned N_SLOT      = 10,
  parameter int unsigned TONE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned BASE_HALF   = 50_000,
  parameter int unsigned STEP_HALF   = 5_000
) (
  input logic               clk,
  input logic               rst,
  buzzer_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e              state_q, state_d;
  logic [4*N_SLOT-1:0] prev_q;
  logic [N_SLOT-1:0]   pending_q, pending_d;
  logic [N_SLOT-1:0]   evt, grant_mask;
  logic [3:0]          last_q, last_d;
  logic [3:0]          active_q, active_d;
  logic [31:0]         tone_q, tone_d;
  logic [31:0]         gap_q, gap_d;
  logic [31:0]         half_q, half_d;
  logic                pin_q, pin_d;

  logic [3:0]          winner;
  logic                found;
  logic                grant;
  logic [31:0]         half_win;   // H-1 for the slot about to be granted
  logic [31:0]         half_act;   // H-1 for the slot currently playing
  int unsigned         idx;

  // Only a nonzero -> zero transition counts as a wrap.
  always_comb begin
    evt = '0;
    for (int unsigned i = 0; i < N_SLOT; i++) begin
      evt[i] = (prev_q[4*i +: 4] != 4'd0) && (bus.status[4*i +: 4] == 4'd0);
    end
  end

  // Round-robin search starting just after the last granted slot.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_SLOT; k++) begin
      idx = (32'(last_q) + k) % N_SLOT;
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        winner = 4'(idx);
      end
    end
  end

  assign half_win = BASE_HALF + 32'(winner) * STEP_HALF - 32'd1;
  assign half_act = BASE_HALF + 32'(active_q) * STEP_HALF - 32'd1;

  always_comb begin
    state_d  = state_q;
    tone_d   = tone_q;
    gap_d    = gap_q;
    half_d   = half_q;
    pin_d    = pin_q;
    active_d = active_q;
    last_d   = last_q;
    grant    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable && found) grant = 1'b1;
      end
      StPlay: begin
        // End of tone takes precedence over a coincident half-period toggle.
        if (tone_q == 32'd0) begin
          pin_d   = 1'b0;
          gap_d   = GAP_CYCLES - 32'd1;
          state_d = StGap;
        end else begin
          tone_d = tone_q - 32'd1;
          if (half_q == 32'd0) begin
            pin_d  = ~pin_q;
            half_d = half_act;
          end else begin
            half_d = half_q - 32'd1;
          end
        end
      end
      StGap: begin
        pin_d = 1'b0;
        if (gap_q == 32'd0) begin
          if (bus.enable && found) grant = 1'b1;
          else                     state_d = StIdle;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      active_d = winner;
      last_d   = winner;
      tone_d   = TONE_CYCLES - 32'd1;
      half_d   = half_win;
      pin_d    = 1'b1;
      state_d  = StPlay;
    end
  end

  // A same-edge event on the granted slot re-sets its flag, giving one replay.
  always_comb begin
    grant_mask = '0;
    for (int unsigned i = 0; i < N_SLOT; i++) begin
      grant_mask[i] = grant && (winner == 4'(i));
    end
    pending_d = (pending_q & ~grant_mask) | evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      pending_q <= '0;
      last_q    <= 4'(N_SLOT - 1);
      active_q  <= '0;
      tone_q    <= '0;
      gap_q     <= '0;
      half_q    <= '0;
      pin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= bus.status;
      pending_q <= pending_d;
      last_q    <= last_d;
      active_q  <= active_d;
      tone_q    <= tone_d;
      gap_q     <= gap_d;
      half_q    <= half_d;
      pin_q     <= pin_d;
    end
  end

  assign bus.buzzer_pin  = pin_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.active_slot = active_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler: expected grant slots are queued as wraps
// are driven and popped whenever a new tone starts on buzzer_pin.
module tb_buzzer_scheduler;
  localparam int unsigned N_SLOT = 10;
  localparam int unsigned TONE   = 20;
  localparam int unsigned GAP    = 4;
  localparam int unsigned BASE   = 2;
  localparam int unsigned STEP   = 1;
  localparam int unsigned PERIOD = TONE + GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  buzzer_scheduler_if #(.N_SLOT(N_SLOT)) bus ();

  buzzer_scheduler #(
    .N_SLOT     (N_SLOT),
    .TONE_CYCLES(TONE),
    .GAP_CYCLES (GAP),
    .BASE_HALF  (BASE),
    .STEP_HALF  (STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;           // edges since reset release
  int unsigned since_grant = 1000;
  int unsigned exp_q[$];
  logic        pin_prev = 1'b0;
  logic        busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (edge %0d): got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // A tone start is a pin rise from idle, or one a full tone+gap after the last start.
  task automatic monitor();
    logic is_grant;
    since_grant++;
    is_grant = bus.buzzer_pin && !pin_prev && (!busy_prev || since_grant >= PERIOD);
    if (is_grant) begin
      if (exp_q.size() == 0) check("unexpected_grant", 32'(bus.active_slot), 32'hffff_ffff);
      else                   check("grant_slot", 32'(bus.active_slot), exp_q.pop_front());
      if (busy_prev) check("grant_spacing", since_grant, PERIOD);
      since_grant = 0;
    end
    pin_prev  = bus.buzzer_pin;
    busy_prev = bus.busy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic step_to(input int unsigned k);
    while (cyc < k) step();
  endtask

  task automatic set_nib(input int unsigned i, input logic [3:0] v);
    bus.status[4*i +: 4] = v;
  endtask

  task automatic clear_monitor();
    cyc = 0;
    pin_prev = 1'b0;
    busy_prev = 1'b0;
    since_grant = 1000;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.status = '0;
    bus.enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_monitor();
  endtask

  task automatic run_until_idle();
    int unsigned n;
    n = 0;
    do begin
      step();
      n++;
    end while ((bus.busy || bus.pending != '0) && n < 500);
    check("idle_reached", 32'(bus.busy), 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned low_cnt;
    logic exp_pin;

    // 1. Single event on slot 3 with exact tone/gap timing.
    do_reset();
    check("rst_pin", 32'(bus.buzzer_pin), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_active", 32'(bus.active_slot), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    set_nib(3, 4'd1);
    step_to(9);
    set_nib(3, 4'd0);
    exp_q.push_back(3);
    step();
    check("t1_pending", 32'(bus.pending), 32'h008);
    check("t1_busy_pre", 32'(bus.busy), 32'd0);
    step();
    check("t1_active", 32'(bus.active_slot), 32'd3);
    check("t1_pending_clr", 32'(bus.pending), 32'd0);
    while (cyc <= 35) begin
      exp_pin = (cyc < 31) ? ((((cyc - 11) / 5) % 2) == 0) : 1'b0;
      check("t1_pin", 32'(bus.buzzer_pin), 32'(exp_pin));
      check("t1_busy", 32'(bus.busy), 32'(cyc < 35));
      step();
    end
    check("t1_queue", exp_q.size(), 32'd0);

    // 2. Simultaneous wraps on slots 0, 4, 9.
    do_reset();
    set_nib(0, 4'd1); set_nib(4, 4'd1); set_nib(9, 4'd1);
    step();
    set_nib(0, 4'd0); set_nib(4, 4'd0); set_nib(9, 4'd0);
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(9);
    step();
    check("t2_pending", 32'(bus.pending), 32'h211);
    low_cnt = 0;
    while (cyc < 74) begin
      step();
      if (!bus.busy) low_cnt++;
    end
    check("t2_busy_low_cycles", low_cnt, 32'd0);
    step();
    check("t2_busy_fall", 32'(bus.busy), 32'd0);
    check("t2_queue", exp_q.size(), 32'd0);

    // 3. Round-robin fairness: after slot 4, slot 6 beats slot 2.
    do_reset();
    set_nib(4, 4'd1);
    step();
    set_nib(4, 4'd0);
    exp_q.push_back(4);
    run_until_idle();
    set_nib(2, 4'd1); set_nib(6, 4'd1);
    step();
    set_nib(2, 4'd0); set_nib(6, 4'd0);
    exp_q.push_back(6); exp_q.push_back(2);
    run_until_idle();

    // 4a. Slot 5 re-wraps during its own tone.
    do_reset();
    set_nib(5, 4'd1);
    step();
    set_nib(5, 4'd0);
    exp_q.push_back(5);
    repeat (7) step();
    set_nib(5, 4'd1);
    step();
    set_nib(5, 4'd0);
    step();
    check("t4a_pending", 32'(bus.pending), 32'h020);
    check("t4a_busy", 32'(bus.busy), 32'd1);
    exp_q.push_back(5);
    run_until_idle();

    // 4b. Grant and new event on slot 5 at the same edge.
    do_reset();
    bus.enable = 1'b0;
    set_nib(5, 4'd1);
    step();
    set_nib(5, 4'd0);
    step();
    check("t4b_pending", 32'(bus.pending), 32'h020);
    set_nib(5, 4'd1);
    step();
    bus.enable = 1'b1;
    set_nib(5, 4'd0);
    exp_q.push_back(5); exp_q.push_back(5);
    step();
    check("t4b_active", 32'(bus.active_slot), 32'd5);
    check("t4b_busy", 32'(bus.busy), 32'd1);
    check("t4b_pending_kept", 32'(bus.pending), 32'h020);
    run_until_idle();

    // 5. Status held at zero fires nothing; enable gates grants only.
    do_reset();
    repeat (30) step();
    check("t5_no_pending", 32'(bus.pending), 32'd0);
    check("t5_no_busy", 32'(bus.busy), 32'd0);
    bus.enable = 1'b0;
    set_nib(7, 4'd1);
    step();
    set_nib(7, 4'd0);
    step();
    check("t5_pending", 32'(bus.pending), 32'h080);
    repeat (10) step();
    check("t5_gated_busy", 32'(bus.busy), 32'd0);
    check("t5_gated_pending", 32'(bus.pending), 32'h080);
    bus.enable = 1'b1;
    exp_q.push_back(7);
    step();
    check("t5_grant_busy", 32'(bus.busy), 32'd1);
    check("t5_grant_active", 32'(bus.active_slot), 32'd7);
    check("t5_grant_pin", 32'(bus.buzzer_pin), 32'd1);
    run_until_idle();

    // 6. Asynchronous reset mid-tone, then slot 0 wins over slot 9.
    do_reset();
    set_nib(8, 4'd1);
    step();
    set_nib(8, 4'd0);
    exp_q.push_back(8);
    step();
    step();
    set_nib(2, 4'd1);
    step();
    set_nib(2, 4'd0);
    step();
    check("t6_pending", 32'(bus.pending), 32'h004);
    repeat (3) step();
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_pin", 32'(bus.buzzer_pin), 32'd0);
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    check("t6_async_pending", 32'(bus.pending), 32'd0);
    bus.status = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_monitor();
    set_nib(0, 4'd1); set_nib(9, 4'd1);
    step();
    set_nib(0, 4'd0); set_nib(9, 4'd0);
    exp_q.push_back(0); exp_q.push_back(9);
    run_until_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
